// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline front end: default reset PC,
// the NOP encoding, the halt sentinel word and the fetch-state encoding.
package mips_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  // sll $0,$0,0
  localparam logic [31:0] DEFAULT_NOP_WORD = 32'h0000_0000;
  localparam logic [31:0] HALT_WORD        = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    FS_BOOT = 2'd0,
    FS_RUN  = 2'd1,
    FS_HALT = 2'd2
  } fetch_state_e;

  // Branch/jump targets are forced word-aligned before reaching the PC.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_pc_gen.sv
// Program counter register with next-PC selection and the PC+4 adder.
// Priority: reset, branch, jump, hold (stall or halt freeze), sequential.
module fetch_pc_gen
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic [31:0] pc,
  output logic [31:0] pc4
);

  logic [31:0] next_pc;

  // Sequential address; wraps modulo 2^32 without any flag.
  always_comb begin
    pc4 = pc + 32'd4;
  end

  // Next-PC mux. The branch comes from an older instruction than the jump,
  // so it wins when both are present; any redirect overrides a hold.
  always_comb begin
    next_pc = pc4;
    if (branch_taken) begin
      next_pc = align_word(branch_target);
    end else if (jump) begin
      next_pc = align_word(jump_target);
    end else if (stall || freeze) begin
      next_pc = pc;
    end
  end

  // PC register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else begin
      pc <= next_pc;
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: drives the instruction memory address, takes the
// combinational read data back and registers it with PC+4 into IF/ID.
// Handles stall, branch/jump redirect with a one-bubble flush, and, when
// IFU_HALT_EN is defined, stopping fetch on the halt word.
//
// if_id_valid qualifies the IF/ID contents: when 0 the register holds a
// bubble (NOP_WORD) that downstream stages must treat as no instruction.
// There is no backpressure handshake; stall is the only hold mechanism.
module instruction_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_WORD = DEFAULT_NOP_WORD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic        halted
);

  // Current fetch state; kept as a named signal so checkers can bind to it.
  fetch_state_e state;
  fetch_state_e next_state;

  logic [31:0] pc;
  logic [31:0] pc4;
  logic        redirect;
  logic        halt_hit;
  logic        freeze;

  assign redirect  = branch_taken | jump;
  assign imem_addr = pc;

`ifdef IFU_HALT_EN
  // Halt word is being latched this cycle as a real instruction.
  assign halt_hit = (state == FS_RUN) && !stall && !redirect &&
                    (imem_data == HALT_WORD);
  // PC stops at the halt word's address and stays there while halted.
  assign freeze   = halt_hit || (state == FS_HALT);
  assign halted   = (state == FS_HALT);
`else
  assign halt_hit = 1'b0;
  assign freeze   = 1'b0;
  assign halted   = 1'b0;
`endif

  fetch_pc_gen #(
    .RESET_PC (RESET_PC)
  ) u_pc_gen (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .freeze        (freeze),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .pc            (pc),
    .pc4           (pc4)
  );

  // Fetch state transitions: BOOT lasts one cycle, HALT exits only on redirect.
  always_comb begin
    next_state = state;
    case (state)
      FS_BOOT: next_state = FS_RUN;
      FS_RUN:  next_state = halt_hit ? FS_HALT : FS_RUN;
      FS_HALT: next_state = redirect ? FS_RUN : FS_HALT;
      default: next_state = FS_BOOT;
    endcase
  end

  // Fetch state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FS_BOOT;
    end else begin
      state <= next_state;
    end
  end

  // IF/ID register: flush on redirect, bubble while halted, hold on stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_id_valid <= 1'b0;
      if_id_instr <= NOP_WORD;
      if_id_pc4   <= 32'd0;
    end else if (redirect) begin
      if_id_valid <= 1'b0;
      if_id_instr <= NOP_WORD;
    end else if (state == FS_HALT) begin
      if_id_valid <= 1'b0;
      if_id_instr <= NOP_WORD;
    end else if (!stall) begin
      if_id_valid <= 1'b1;
      if_id_instr <= imem_data;
      if_id_pc4   <= pc4;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit. The instruction memory is a
// 64-word array: word at byte address A holds 32'h1000_0000 + A/4, except
// address 0x10 which holds the halt word 32'hFFFF_FFFF.
module tb_instruction_fetch_unit;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic        halted;

  logic [31:0] mem [64];

  int n_tests;
  int n_fail;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign imem_data = mem[imem_addr[7:2]];

  instruction_fetch_unit dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .if_id_instr   (if_id_instr),
    .if_id_pc4     (if_id_pc4),
    .if_id_valid   (if_id_valid),
    .halted        (halted)
  );

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 32'd0;
    jump          = 1'b0;
    jump_target   = 32'd0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_addr"},   imem_addr,   32'h0000_0000);
    check({tag, "_valid"},  {31'd0, if_id_valid}, 32'd0);
    check({tag, "_instr"},  if_id_instr, 32'h0000_0000);
    check({tag, "_pc4"},    if_id_pc4,   32'h0000_0000);
    check({tag, "_halted"}, {31'd0, halted}, 32'd0);
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] instr,
                            input logic [31:0] pc4, input logic valid,
                            input logic [31:0] addr);
    check({tag, "_instr"}, if_id_instr, instr);
    check({tag, "_pc4"},   if_id_pc4,   pc4);
    check({tag, "_valid"}, {31'd0, if_id_valid}, {31'd0, valid});
    check({tag, "_addr"},  imem_addr,   addr);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_tests = 0;
    n_fail  = 0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + i;
    mem[4] = 32'hFFFF_FFFF;
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    check_reset("reset");

    // Free-running fetch from 0.
    rst = 1'b0;
    step();
    check_ifid("seq0", 32'h1000_0000, 32'd4, 1'b1, 32'd4);
    step();
    check_ifid("seq1", 32'h1000_0001, 32'd8, 1'b1, 32'd8);

    // Stall three cycles at PC=8.
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_ifid("stall", 32'h1000_0001, 32'd8, 1'b1, 32'd8);
    end
    stall = 1'b0;
    step();
    check_ifid("resume2", 32'h1000_0002, 32'd12, 1'b1, 32'd12);
    step();
    check_ifid("seq3", 32'h1000_0003, 32'd16, 1'b1, 32'd16);

    // Halt word at 0x10.
    step();
`ifdef IFU_HALT_EN
    check_ifid("haltword", 32'hFFFF_FFFF, 32'h14, 1'b1, 32'h10);
    check("halt_set", {31'd0, halted}, 32'd1);
    step();
    check_ifid("halt_bubble", 32'h0, 32'h14, 1'b0, 32'h10);
    check("halt_hold", {31'd0, halted}, 32'd1);
`else
    check_ifid("haltword", 32'hFFFF_FFFF, 32'h14, 1'b1, 32'h14);
    check("halt_none", {31'd0, halted}, 32'd0);
`endif

    // Jump to 0x20: one bubble, then the target word.
    jump = 1'b1;
    jump_target = 32'h20;
    step();
    idle_inputs();
    check("jmp_bubble_valid", {31'd0, if_id_valid}, 32'd0);
    check("jmp_bubble_instr", if_id_instr, 32'h0);
    check("jmp_addr", imem_addr, 32'h20);
    check("jmp_halted", {31'd0, halted}, 32'd0);
    step();
    check_ifid("jmp_tgt", 32'h1000_0008, 32'h24, 1'b1, 32'h24);

    // Branch beats jump and stall together.
    branch_taken  = 1'b1;
    branch_target = 32'h40;
    jump          = 1'b1;
    jump_target   = 32'h80;
    stall         = 1'b1;
    step();
    idle_inputs();
    check("prio_valid", {31'd0, if_id_valid}, 32'd0);
    check("prio_instr", if_id_instr, 32'h0);
    check("prio_addr",  imem_addr,   32'h40);
    step();
    check_ifid("prio_tgt", 32'h1000_0010, 32'h44, 1'b1, 32'h44);

    // Unaligned target is word-aligned.
    jump = 1'b1;
    jump_target = 32'h43;
    step();
    idle_inputs();
    check("align_addr", imem_addr, 32'h40);
    step();
    check_ifid("align_tgt", 32'h1000_0010, 32'h44, 1'b1, 32'h44);

    // PC+4 wraps at the top of the address space.
    branch_taken  = 1'b1;
    branch_target = 32'hFFFF_FFFC;
    step();
    idle_inputs();
    check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    step();
    check_ifid("wrap", 32'h1000_003F, 32'h0, 1'b1, 32'h0);
    step();
    check_ifid("wrap_next", 32'h1000_0000, 32'h4, 1'b1, 32'h4);

    // Reset during stall.
    stall = 1'b1;
    rst   = 1'b1;
    step();
    check_reset("rst_stall");
    rst   = 1'b0;
    stall = 1'b0;
    step();
    check_ifid("post_rst", 32'h1000_0000, 32'd4, 1'b1, 32'd4);

    // Reset while halted (or, without halt support, during a redirect).
    jump = 1'b1;
    jump_target = 32'h10;
    step();
    idle_inputs();
    step();
    check("pre_rst_instr", if_id_instr, 32'hFFFF_FFFF);
    jump = 1'b1;
    jump_target = 32'h30;
    rst  = 1'b1;
    step();
    check_reset("rst_halt");
    rst = 1'b0;
    idle_inputs();
    step();
    check_ifid("post_rst2", 32'h1000_0000, 32'd4, 1'b1, 32'd4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Instruction fetch stage for the MIPS pipeline. It is the requester for the instruction memory: it owns the program counter, drives the word address into the memory, and accepts the combinational read data back. It registers each fetched word with its PC+4 into the IF/ID pipeline register. It also handles stall, branch/jump redirect with flush, and, optionally, halt detection.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `NOP_WORD`, default 32'h0000_0000: instruction driven on `if_id_instr` when invalid (sll $0,$0,0).

Ports:
- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `stall` input 1: hazard unit hold request; freezes PC and IF/ID.
- `branch_taken` input 1: resolved taken branch this cycle.
- `branch_target` input 32: branch destination.
- `jump` input 1: jump (j/jal/jr) this cycle.
- `jump_target` input 32: jump destination.
- `imem_addr` output 32: byte address to instruction memory; equals PC.
- `imem_data` input 32: instruction word returned combinationally for `imem_addr`.
- `if_id_instr` output 32: registered instruction.
- `if_id_pc4` output 32: registered PC+4 of that instruction.
- `if_id_valid` output 1: IF/ID holds a real instruction.
- `halted` output 1: fetch stopped on halt word (always 0 without `IFU_HALT_EN`).

## Operation
- State machine with states BOOT, RUN and HALT.
  - BOOT: first cycle after reset. Fetches at `RESET_PC`, always goes to RUN.
  - RUN: normal fetch.
  - HALT: PC frozen; exists only with `IFU_HALT_EN`.
- Each cycle in which IF/ID updates, `imem_data` and PC+4 are latched together.
- Next-PC priority, highest first:
  1. `rst`: PC <= `RESET_PC`.
  2. `branch_taken`: PC <= `branch_target`. The branch is older than a jump in ID, so it wins when both are asserted.
  3. `jump`: PC <= `jump_target`.
  4. `stall`: PC held.
  5. Otherwise PC <= PC+4.
- Redirect (`branch_taken` or `jump`):
  - The wrong-path word in IF/ID is flushed: `if_id_valid` <= 0 and `if_id_instr` <= `NOP_WORD`.
  - Redirect beats `stall` in the same cycle.
- Stall without redirect: PC, `if_id_instr`, `if_id_pc4` and `if_id_valid` all hold their values.
- Targets have bits [1:0] forced to 0 before loading into PC, so `imem_addr[1:0]` is always 2'b00.
- PC+4 uses 32-bit modulo arithmetic; 32'hFFFF_FFFC+4 wraps to 0 with no flag.

## Timing
- Reset values: PC = `RESET_PC`, so `imem_addr` = `RESET_PC`. Also `if_id_valid` = 0, `if_id_instr` = `NOP_WORD`, `if_id_pc4` = 0, `halted` = 0, state = BOOT.
- Fetch latency: address is driven in cycle N, data is read the same cycle, and the word appears on `if_id_instr` after the edge ending cycle N.
- First valid instruction: the edge after reset deasserts. `if_id_valid` = 1 with `if_id_pc4` = `RESET_PC`+4.
- Redirect penalty: exactly one bubble in IF/ID. The target instruction appears with valid=1 one cycle after the bubble.
- Reset asserted mid-operation: takes effect at the next edge regardless of stall, redirect or HALT.

## Configuration
- Macro: `IFU_HALT_EN`.
- Defined:
  - When a word equal to 32'hFFFF_FFFF is latched into IF/ID (not stalled, not redirected), the state goes to HALT.
  - In HALT: `halted` = 1, PC frozen, `if_id_valid` = 0 from the following edge.
  - A redirect arriving in HALT (from an older branch) returns to RUN and fetches the target. `halted` deasserts at that edge.
  - Only `rst` or a redirect leaves HALT.
- Undefined: 32'hFFFF_FFFF is fetched as an ordinary word, the HALT state is absent, and `halted` is tied to 0.

## Structure
- Shared package `mips_pkg`: `RESET_PC` default, `NOP_WORD`, `HALT_WORD` (32'hFFFF_FFFF), and the fetch-state enum (BOOT, RUN, HALT).
- One sub-module, `fetch_pc_gen`: PC register, next-PC priority mux, target alignment, and the PC+4 adder.
- The top level holds the FSM and the IF/ID register, and drives `imem_addr`.

## Test plan
- Reset release, then 4 free-running cycles against a memory holding words W0–W3 → `if_id_instr` = W0..W3 on successive cycles, `if_id_pc4` = 4, 8, 12, 16, valid = 1 after the first edge.
- `stall` held for 3 cycles at PC=8 → `imem_addr` stays 8 and IF/ID holds for 3 cycles; sequential fetch resumes at 12.
- `branch_taken`=1 with target 0x40, asserted together with `stall` and `jump` (target 0x80) → one bubble (valid=0, instr = `NOP_WORD`), then the instruction at 0x40 with pc4 = 0x44.
- Target 0x43 → `imem_addr` = 0x40; PC at 32'hFFFF_FFFC advances to 0.
- With `IFU_HALT_EN`, word 32'hFFFF_FFFF at 0x10 → `halted`=1, PC frozen. A later `jump` to 0x20 → `halted`=0 and fetch resumes at 0x20. Without `IFU_HALT_EN`, the same word passes through with valid=1.
- `rst` asserted during stall and during HALT → all outputs take their reset values at the next edge.
